// File: rtl/dft_pkg.sv
// Shared DFT probe-network types: observe/inject cell state encoding and parity helper.
package dft_pkg;

  typedef enum logic {
    DFT_IDLE  = 1'b0,
    DFT_SHIFT = 1'b1
  } dft_state_e;

  // Even parity over a zero-extended word; zero padding does not change the result.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/dft_tdo_observe.sv
// Serial observe cell: captures WIDTH probe nets on a strobe and shifts them out LSB-first on tdo.
// Define DFT_TDO_PARITY_EN to append an even-parity bit after the last probe bit.
module dft_tdo_observe
  import dft_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ten,
  input  logic             cap,
  input  logic             shen,
  input  logic [WIDTH-1:0] probe,
  output logic             tdo,
  output logic             busy,
  output logic             done,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             CELSUB
);

`ifdef DFT_TDO_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  dft_state_e    state, state_nxt;
  logic [NB-1:0] sreg, sreg_nxt, cap_word;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          tdo_nxt, done_nxt;

  // Supply/substrate pins exist only for netlist parity.
  logic unused_supply;
  assign unused_supply = ^{CELV, CELG, CELSUB};

`ifdef DFT_TDO_PARITY_EN
  assign cap_word = {even_parity(64'(probe)), probe};
`else
  assign cap_word = probe;
`endif

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    tdo_nxt   = 1'b0;
    done_nxt  = 1'b0;
    if (!ten) begin
      // Abort wins over cap/shen; no done pulse.
      state_nxt = DFT_IDLE;
    end else begin
      case (state)
        DFT_IDLE: begin
          if (cap) begin
            sreg_nxt  = cap_word;
            cnt_nxt   = '0;
            state_nxt = DFT_SHIFT;
            tdo_nxt   = probe[0];
          end
        end
        DFT_SHIFT: begin
          tdo_nxt = tdo;
          if (shen) begin
            sreg_nxt = sreg >> 1;
            cnt_nxt  = cnt + 1'b1;
            if (cnt == LAST) begin
              state_nxt = DFT_IDLE;
              done_nxt  = 1'b1;
              tdo_nxt   = 1'b0;
            end else begin
              tdo_nxt = sreg[1];
            end
          end
        end
        default: state_nxt = DFT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DFT_IDLE;
      sreg  <= '0;
      cnt   <= '0;
      tdo   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
      tdo   <= tdo_nxt;
      done  <= done_nxt;
    end
  end

  assign busy = (state == DFT_SHIFT);

endmodule

// File: tb/tb_dft_tdo_observe.sv
// Self-checking bench for dft_tdo_observe (WIDTH=8); expected bit streams are queued at capture.
module tb_dft_tdo_observe;

  localparam int WIDTH = 8;
`ifdef DFT_TDO_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst, ten, cap, shen;
  logic [WIDTH-1:0] probe;
  logic tdo, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  dft_tdo_observe #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .ten(ten), .cap(cap), .shen(shen), .probe(probe),
    .tdo(tdo), .busy(busy), .done(done),
    .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the bit stream the cell should emit for a captured word.
  task automatic push_bits(input logic [WIDTH-1:0] p);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(p[i]);
`ifdef DFT_TDO_PARITY_EN
    exp_q.push_back(^p);
`endif
  endtask

  task automatic start_capture(input logic [WIDTH-1:0] p);
    probe = p;
    cap   = 1'b1;
    exp_q.delete();
    push_bits(p);
    tick();
    cap  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ten = 1'b1; cap = 1'b1; shen = 1'b1; probe = 8'hFF;
    tick(); tick();
    n_cmp++;
    if ({tdo, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL reset_outputs: got tdo/busy/done=%b expected 000", {tdo, busy, done});
    end
    rst = 1'b0; cap = 1'b0; shen = 1'b0;
    tick();
    n_cmp++;
    if ({tdo, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL idle_after_reset: got tdo/busy/done=%b expected 000", {tdo, busy, done});
    end
  endtask

  task automatic test_basic(input logic [WIDTH-1:0] p);
    start_capture(p);
    shen = 1'b1;
    for (int i = 0; i < NB; i++) begin
      logic e;
      e = exp_q.pop_front();
      n_cmp++;
      if (tdo !== e || busy !== 1'b1 || done !== 1'b0) begin
        n_err++; $display("FAIL basic_bit%0d p=%h: got tdo=%b busy=%b done=%b expected tdo=%b busy=1 done=0",
                          i, p, tdo, busy, done, e);
      end
      tick();
    end
    n_cmp++;
    if ({tdo, busy, done} !== 3'b001) begin
      n_err++; $display("FAIL basic_done p=%h: got tdo/busy/done=%b expected 001", p, {tdo, busy, done});
    end
    tick();
    n_cmp++;
    if ({tdo, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL basic_after_done: got tdo/busy/done=%b expected 000", {tdo, busy, done});
    end
    shen = 1'b0;
  endtask

  task automatic test_stall();
    int cyc;
    start_capture(8'hA5);
    shen = 1'b1;
    cyc = 1;
    for (int i = 0; i < NB; i++) begin
      logic e;
      e = exp_q.pop_front();
      n_cmp++;
      if (tdo !== e || busy !== 1'b1) begin
        n_err++; $display("FAIL stall_bit%0d: got tdo=%b busy=%b expected tdo=%b busy=1", i, tdo, busy, e);
      end
      if (i == 2) begin
        shen = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick(); cyc++;
          n_cmp++;
          if (tdo !== e || busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL stall_hold%0d: got tdo=%b busy=%b done=%b expected tdo=%b busy=1 done=0",
                              s, tdo, busy, done, e);
          end
        end
        shen = 1'b1;
      end
      tick(); cyc++;
    end
    n_cmp++;
    if (done !== 1'b1 || cyc != NB + 4) begin
      n_err++; $display("FAIL stall_done: got done=%b at cycle %0d expected done=1 at cycle %0d", done, cyc, NB + 4);
    end
    shen = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int done_seen;
    start_capture(8'hC3);
    shen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      void'(exp_q.pop_front());
      tick();
    end
    n_cmp++;
    if (tdo !== exp_q[0]) begin
      n_err++; $display("FAIL abort_bit4: got tdo=%b expected %b", tdo, exp_q[0]);
    end
    ten = 1'b0;
    tick();
    n_cmp++;
    if ({tdo, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL abort_next: got tdo/busy/done=%b expected 000", {tdo, busy, done});
    end
    done_seen = 0;
    for (int i = 0; i < NB + 2; i++) begin
      tick();
      if (done) done_seen++;
    end
    n_cmp++;
    if (done_seen != 0) begin
      n_err++; $display("FAIL abort_no_done: got %0d done pulses expected 0", done_seen);
    end
    ten = 1'b1; shen = 1'b0;
    tick();
    test_basic(8'h3C);
  endtask

  task automatic test_ignored_strobes();
    ten = 1'b0; cap = 1'b1; probe = 8'hFF;
    tick(); tick();
    n_cmp++;
    if ({tdo, busy} !== 2'b00) begin
      n_err++; $display("FAIL cap_ten_low: got tdo/busy=%b expected 00", {tdo, busy});
    end
    cap = 1'b0; ten = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL no_late_capture: got busy=%b expected 0", busy);
    end
    start_capture(8'h5A);
    shen = 1'b1;
    for (int i = 0; i < NB; i++) begin
      logic e;
      e = exp_q.pop_front();
      n_cmp++;
      if (tdo !== e || busy !== 1'b1) begin
        n_err++; $display("FAIL midshift_cap_bit%0d: got tdo=%b busy=%b expected tdo=%b busy=1", i, tdo, busy, e);
      end
      cap   = (i == 3);
      probe = (i == 3) ? 8'hFF : 8'h5A;
      tick();
    end
    cap = 1'b0;
    n_cmp++;
    if ({tdo, busy, done} !== 3'b001) begin
      n_err++; $display("FAIL midshift_cap_done: got tdo/busy/done=%b expected 001", {tdo, busy, done});
    end
    shen = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    start_capture(8'hA5);
    shen = 1'b1;
    for (int i = 0; i < NB; i++) tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL b2b_first_done: got done=%b expected 1", done);
    end
    start_capture(8'h07);
    for (int i = 0; i < NB; i++) begin
      logic e;
      e = exp_q.pop_front();
      n_cmp++;
      if (tdo !== e || busy !== 1'b1) begin
        n_err++; $display("FAIL b2b_bit%0d: got tdo=%b busy=%b expected tdo=%b busy=1", i, tdo, busy, e);
      end
      tick();
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL b2b_second_done: got done=%b expected 1", done);
    end
    shen = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic(8'hA5);
    test_basic(8'h07);
    test_stall();
    test_abort();
    test_ignored_strobes();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
